// File: rtl/fads_pkg.sv
// Shared definitions for the FADS sort scheduler: bus map, FSM encoding, reset defaults.
// Pure declarations; no latency or flow control of its own.
package fads_pkg;

  localparam logic [19:0] ADDR_CTRL     = 20'h00000;
  localparam logic [19:0] ADDR_DELAY    = 20'h00004;
  localparam logic [19:0] ADDR_PULSE    = 20'h00008;
  localparam logic [19:0] ADDR_HOLDOFF  = 20'h0000C;
  localparam logic [19:0] ADDR_LATE_TOL = 20'h00010;
  localparam logic [19:0] ADDR_LEVEL    = 20'h00100;
  localparam logic [19:0] ADDR_FIRED    = 20'h00104;
  localparam logic [19:0] ADDR_OVERFLOW = 20'h00108;
  localparam logic [19:0] ADDR_LATE     = 20'h0010C;

  localparam logic [31:0] RST_DELAY     = 32'd0;
  localparam logic [31:0] RST_PULSE_LEN = 32'd125000;
  localparam logic [31:0] RST_HOLDOFF   = 32'd0;
  localparam logic [31:0] RST_LATE_TOL  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_PULSE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/fads_event_fifo.sv
// Show-ahead FIFO of due timestamps; push ignored when full, pop ignored when empty.
// One-cycle write latency; flush empties it in one cycle and wins over push/pop.
module fads_event_fifo #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (!do_push && do_pop) level <= level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/red_pitaya_fads_sort_sched.sv
// Queues positive-droplet events with a due time and fires timed sort pulses with hold-off.
// Trigger rises delay+3 cycles after det_valid_i from idle; full queue drops and counts events.
module red_pitaya_fads_sort_sched
  import fads_pkg::*;
#(
  parameter int QSZ = 3,
  parameter int TSW = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic        det_valid_i,
  output logic        sort_trig_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam logic [TSW-1:0] CNT_MAX = '1;

  logic [TSW-1:0] ts, delay, pulse_len, holdoff, late_tol;
  logic [TSW-1:0] fired, overflow, late_cnt, cnt;
  logic [TSW-1:0] head, head_age;
  logic [QSZ:0]   level;
  logic           enable, flush, det_q, full, empty;
  logic           pop, fire, late_ev, load_hold, dispatch, head_due, head_late;
  state_t         state, state_nxt;
  logic [19:0]    addr;
  logic [31:0]    rd_mux;
  logic           unused_ok;

  assign addr      = sys_addr[19:0];
  assign unused_ok = ^{sys_sel, sys_addr[31:20]};
  assign flush     = sys_wen && (addr == ADDR_CTRL) && sys_wdata[1];
  assign sys_err   = 1'b0;
  assign busy_o    = !empty || (state != S_IDLE);

  fads_event_fifo #(.W(TSW), .AW(QSZ)) u_fifo (
    .clk   (adc_clk_i),
    .rst   (adc_rst_i),
    .flush (flush),
    .push  (det_q),
    .pop   (pop),
    .din   (ts + delay),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Signed age test stays correct across timestamp wrap while delay < 2^(TSW-1).
  assign head_age  = ts - head;
  assign head_due  = !head_age[TSW-1];
  assign head_late = head_age > late_tol;

  // IDLE, ARM and the last PULSE/HOLD cycle all run the same dispatch check, so an
  // overdue entry starts its pulse right after hold-off with no extra gap cycles.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fire      = 1'b0;
    late_ev   = 1'b0;
    load_hold = 1'b0;
    dispatch  = 1'b0;
    case (state)
      S_IDLE, S_ARM: dispatch = 1'b1;
      S_PULSE: begin
        if (cnt == '0) begin
          if (holdoff == '0) begin
            dispatch = 1'b1;
          end else begin
            state_nxt = S_HOLD;
            load_hold = 1'b1;
          end
        end
      end
      S_HOLD:  if (cnt == '0) dispatch = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
    if (dispatch) begin
      if (empty) begin
        state_nxt = S_IDLE;
      end else if (!head_due) begin
        state_nxt = S_ARM;
      end else begin
        pop = 1'b1;
        if (head_late) begin
          late_ev   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          fire      = 1'b1;
          state_nxt = S_PULSE;
        end
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      ts          <= '0;
      det_q       <= 1'b0;
      state       <= S_IDLE;
      cnt         <= '0;
      sort_trig_o <= 1'b0;
      fired       <= '0;
      overflow    <= '0;
      late_cnt    <= '0;
    end else begin
      ts    <= ts + TSW'(1);
      det_q <= det_valid_i && enable && !flush;
      if (flush) begin
        state       <= S_IDLE;
        sort_trig_o <= 1'b0;
      end else begin
        state       <= state_nxt;
        sort_trig_o <= (state == S_PULSE);
      end
      if (fire)           cnt <= (pulse_len == '0) ? '0 : pulse_len - TSW'(1);
      else if (load_hold) cnt <= holdoff - TSW'(1);
      else if (cnt != '0) cnt <= cnt - TSW'(1);
      if (fire && !flush && fired != CNT_MAX)       fired    <= fired + TSW'(1);
      if (late_ev && !flush && late_cnt != CNT_MAX) late_cnt <= late_cnt + TSW'(1);
      if (det_q && full && overflow != CNT_MAX)     overflow <= overflow + TSW'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL:     rd_mux = {31'b0, enable};
      ADDR_DELAY:    rd_mux = 32'(delay);
      ADDR_PULSE:    rd_mux = 32'(pulse_len);
      ADDR_HOLDOFF:  rd_mux = 32'(holdoff);
      ADDR_LATE_TOL: rd_mux = 32'(late_tol);
      ADDR_LEVEL:    rd_mux = 32'(level);
      ADDR_FIRED:    rd_mux = 32'(fired);
      ADDR_OVERFLOW: rd_mux = 32'(overflow);
      ADDR_LATE:     rd_mux = 32'(late_cnt);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      enable    <= 1'b1;
      delay     <= TSW'(RST_DELAY);
      pulse_len <= TSW'(RST_PULSE_LEN);
      holdoff   <= TSW'(RST_HOLDOFF);
      late_tol  <= TSW'(RST_LATE_TOL);
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen || sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
      if (sys_wen) begin
        case (addr)
          ADDR_CTRL:     enable    <= sys_wdata[0];
          ADDR_DELAY:    delay     <= TSW'(sys_wdata);
          ADDR_PULSE:    pulse_len <= TSW'(sys_wdata);
          ADDR_HOLDOFF:  holdoff   <= TSW'(sys_wdata);
          ADDR_LATE_TOL: late_tol  <= TSW'(sys_wdata);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// Bench for the FADS sort scheduler: register table plus scheduled-pulse scoreboard.
module tb_red_pitaya_fads_sort_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        det = 1'b0;
  logic        wen = 1'b0;
  logic        ren = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = 4'hF;
  logic        trig, busy, err, ack;
  logic [31:0] rdata;

  red_pitaya_fads_sort_sched dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .det_valid_i (det),
    .sort_trig_o (trig),
    .busy_o      (busy),
    .sys_addr    (addr),
    .sys_wdata   (wdata),
    .sys_sel     (sel),
    .sys_wen     (wen),
    .sys_ren     (ren),
    .sys_rdata   (rdata),
    .sys_err     (err),
    .sys_ack     (ack)
  );

  always #4 clk = ~clk;

  typedef struct { int start; int width; } exp_t;
  typedef struct { bit wr; logic [31:0] a; logic [31:0] d; logic [31:0] exp; } vec_t;

  exp_t expq[$];
  vec_t tbl[14];
  int   cyc = 0, n_checks = 0, n_fail = 0, gate = 0;
  int   m_delay = 0, m_pulse = 125000, m_hold = 0;
  bit   trig_prev = 1'b0, have_cur = 1'b0;
  int   cur_start = 0, cur_width = 0;
  int   s0;
  logic [31:0] rd;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge and score any pulse edges seen.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (trig && !trig_prev) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: rising edge at cycle %0d, none required", cyc);
      end else begin
        e = expq.pop_front();
        chk("pulse_start", cyc, e.start);
        have_cur  = 1'b1;
        cur_start = cyc;
        cur_width = e.width;
      end
    end
    if (!trig && trig_prev && have_cur) begin
      chk("pulse_width", cyc - cur_start, cur_width);
      have_cur = 1'b0;
    end
    trig_prev = trig;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    step();
    d = rdata;
    chk("sys_ack", ack, 1);
    ren = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    chk(name, v, exp);
  endtask

  task automatic cfg(input int d, input int p, input int h, input logic [31:0] tol);
    bus_write(32'h04, d);
    bus_write(32'h08, p);
    bus_write(32'h0C, h);
    bus_write(32'h10, tol);
    m_delay = d; m_pulse = p; m_hold = h;
  endtask

  // One detector event this cycle; the model schedules it if it is expected to fire.
  task automatic ev(input bit fires);
    int s;
    det = 1'b1;
    if (fires) begin
      s = cyc + m_delay + 3;
      if (gate > s) s = gate;
      expq.push_back('{s, m_pulse});
      gate = s + m_pulse + m_hold;
    end
    step();
    det = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; det = 1'b0; wen = 1'b0; ren = 1'b0;
    step();
    step();
    rst = 1'b0;
    gate = 0; m_delay = 0; m_pulse = 125000; m_hold = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h000, 32'h0,    32'h1};
    tbl[1]  = '{1'b0, 32'h004, 32'h0,    32'h0};
    tbl[2]  = '{1'b0, 32'h008, 32'h0,    32'd125000};
    tbl[3]  = '{1'b0, 32'h00C, 32'h0,    32'h0};
    tbl[4]  = '{1'b0, 32'h010, 32'h0,    32'hFFFF_FFFF};
    tbl[5]  = '{1'b0, 32'h100, 32'h0,    32'h0};
    tbl[6]  = '{1'b0, 32'h104, 32'h0,    32'h0};
    tbl[7]  = '{1'b0, 32'h108, 32'h0,    32'h0};
    tbl[8]  = '{1'b0, 32'h10C, 32'h0,    32'h0};
    tbl[9]  = '{1'b0, 32'h2000, 32'h0,   32'h0};
    tbl[10] = '{1'b1, 32'h004, 32'h1234, 32'h1234};
    tbl[11] = '{1'b1, 32'h00C, 32'h7,    32'h7};
    tbl[12] = '{1'b1, 32'h000, 32'h3,    32'h1};
    tbl[13] = '{1'b1, 32'h000, 32'h0,    32'h0};

    // Reset state
    step();
    step();
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
      bus_read(tbl[i].a, rd);
      chk($sformatf("reg_0x%0h", tbl[i].a), rd, tbl[i].exp);
    end

    // enable is 0 here: an event must be ignored and not counted
    ev(1'b0);
    wait_cycles(3);
    rd_chk("disabled_level", 32'h100, 0);
    rd_chk("disabled_overflow", 32'h108, 0);

    // Single event latency and width
    do_reset();
    cfg(100, 10, 0, 32'hFFFF_FFFF);
    ev(1'b1);
    wait_cycles(10);
    chk("busy_queued", busy, 1);
    wait_cycles(130);
    chk("busy_idle", busy, 0);
    rd_chk("t1_fired", 32'h104, 1);

    // Three events gated by pulse + hold-off
    do_reset();
    cfg(50, 20, 30, 32'hFFFF_FFFF);
    ev(1'b1); wait_cycles(4);
    ev(1'b1); wait_cycles(4);
    ev(1'b1);
    wait_cycles(250);
    rd_chk("t2_late", 32'h10C, 0);
    rd_chk("t2_fired", 32'h104, 3);

    // Same pattern with tight late tolerance
    do_reset();
    cfg(50, 20, 30, 10);
    ev(1'b1); wait_cycles(4);
    ev(1'b0); wait_cycles(4);
    ev(1'b0);
    wait_cycles(250);
    rd_chk("t3_fired", 32'h104, 1);
    rd_chk("t3_late", 32'h10C, 2);

    // Overflow: ten back-to-back events into an eight-deep queue
    do_reset();
    cfg(1000, 10, 5, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) ev(i < 8);
    rd_chk("t4_level", 32'h100, 8);
    rd_chk("t4_overflow", 32'h108, 2);
    wait_cycles(1200);
    rd_chk("t4_fired", 32'h104, 8);
    chk("t4_pending", expq.size(), 0);

    // Timestamp wrap
    do_reset();
    cfg(40, 10, 0, 32'hFFFF_FFFF);
    force dut.ts = 32'hFFFF_FFF0;
    step();
    release dut.ts;
    step();
    ev(1'b1);
    wait_cycles(60);
    rd_chk("t5_fired", 32'h104, 1);

    // Flush mid-pulse with three entries still queued
    do_reset();
    cfg(20, 50, 0, 32'hFFFF_FFFF);
    ev(1'b1); ev(1'b0); ev(1'b0); ev(1'b0);
    s0 = expq[0].start;
    expq[0].width = 11;
    while (cyc < s0 + 10) step();
    bus_write(32'h000, 32'h3);
    chk("flush_trig_low", trig, 0);
    rd_chk("flush_level", 32'h100, 0);
    wait_cycles(150);
    rd_chk("flush_fired", 32'h104, 1);

    // Reset mid-pulse
    ev(1'b1);
    s0 = expq[0].start;
    expq[0].width = 6;
    while (cyc < s0 + 5) step();
    rst = 1'b1;
    step();
    chk("rst_mid_trig", trig, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_read(tbl[i].a, rd);
      chk($sformatf("post_rst_0x%0h", tbl[i].a), rd, tbl[i].exp);
    end
    wait_cycles(5);
    chk("final_pending", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
